spi_cmd_regfile: RTL and testbench

Command decoder and register file downstream of the SPI slave byte engine. Consumes received bytes and frame boundaries, decodes a one-byte command (read/write plus address), performs register writes, and supplies the next byte for the slave to shift out on MISO. Drives the board LED and a control byte from the register contents.

---
 rtl/spi_cmd_regfile.sv | 141 ++++++++++++++
 tb/tb_spi_cmd_regfile.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder and 8-bit register file fed by the slave byte engine.
// Build option: define SPI_REGS_AUTOINC_EN for burst (auto-incrementing) access.
module spi_cmd_regfile #(
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic [7:0] ctrl_out,
    output logic       LED,
    output logic       err,
    output logic [2:0] state_dbg_o
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          tx_q, tx_d;
    logic                err_q, err_d;
    logic [7:0]          regs_q [NUM_REGS];
    logic                wr_en;

    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   next_addr;
    logic                rsvd_bad;
    logic [7:0]          cmd_rd;
    logic [7:0]          next_rd;

    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign rsvd_bad = (rx_byte[6:0] >> ADDR_W) != 7'd0;

`ifdef SPI_REGS_AUTOINC_EN
    assign next_addr = addr_q + ADDR_W'(1);
`else
    assign next_addr = addr_q;
`endif

    // Address 0 is a read-only ID; its storage slot is never written.
    assign cmd_rd  = (cmd_addr  == '0) ? ID_VAL : regs_q[cmd_addr];
    assign next_rd = (next_addr == '0) ? ID_VAL : regs_q[next_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // frame_start dominates everything; frame_end applies after the byte is handled.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_CMD;
        end else begin
            if (rx_valid && state_q == ST_CMD) begin
                if (rsvd_bad) begin
                    state_d = ST_DISCARD;
                end else if (rx_byte[7]) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            if (frame_end) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        tx_d   = tx_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        if (frame_start) begin
            tx_d = 8'h00;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: err_d = 1'b1;
                ST_CMD: begin
                    if (rsvd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = cmd_addr;
                        if (rx_byte[7]) begin
                            tx_d = cmd_rd;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_en  = (addr_q != '0);
                    addr_d = next_addr;
                end
                ST_READ: begin
                    addr_d = next_addr;
                    tx_d   = next_rd;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            tx_q   <= 8'h00;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            addr_q <= addr_d;
            tx_q   <= tx_d;
            err_q  <= err_d;
            if (wr_en) begin
                regs_q[addr_q] <= rx_byte;
            end
        end
    end

    assign tx_byte     = tx_q;
    assign ctrl_out    = regs_q[1];
    assign LED         = regs_q[1][0];
    assign err         = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile; expectations follow SPI_REGS_AUTOINC_EN if defined.
module tb_spi_cmd_regfile;
    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [7:0] ctrl_out;
    logic       LED;
    logic       err;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_CMD = 3'd1, S_WRITE = 3'd2,
                           S_READ = 3'd3, S_DISCARD = 3'd4;

    spi_cmd_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .ctrl_out    (ctrl_out),
        .LED         (LED),
        .err         (err),
        .state_dbg_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_ctrl", ctrl_out, 8'h00);
        chk("rst_led", {7'd0, LED}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        chk("rst_state", {5'd0, state_dbg}, {5'd0, S_IDLE});

        // ID read at address 0
        start_frame();
        chk("fs_state", {5'd0, state_dbg}, {5'd0, S_CMD});
        send(8'h80);
        chk("id_tx", tx_byte, 8'hA5);
        chk("id_err", {7'd0, err}, 8'h00);
        chk("id_state", {5'd0, state_dbg}, {5'd0, S_READ});
        send(8'h00);
`ifdef SPI_REGS_AUTOINC_EN
        chk("id_dummy_tx", tx_byte, 8'h00);
`else
        chk("id_dummy_tx", tx_byte, 8'hA5);
`endif
        end_frame();
        chk("fe_state", {5'd0, state_dbg}, {5'd0, S_IDLE});

        // Control register writes
        start_frame(); send(8'h01); send(8'h3C);
        chk("w3c_ctrl", ctrl_out, 8'h3C);
        chk("w3c_led", {7'd0, LED}, 8'h00);
        end_frame();
        start_frame(); send(8'h01); send(8'h01);
        chk("w01_led", {7'd0, LED}, 8'h01);
        chk("w01_ctrl", ctrl_out, 8'h01);
        end_frame();

        // Burst write crossing the top address
        start_frame(); send(8'h0E); send(8'h11); send(8'h22); send(8'h33); end_frame();
        chk("burst_ctrl", ctrl_out, 8'h01);
        start_frame(); send(8'h8F);
`ifdef SPI_REGS_AUTOINC_EN
        chk("rd15_tx", tx_byte, 8'h22);
        send(8'h00);
        chk("rd15_wrap_tx", tx_byte, 8'hA5);
`else
        chk("rd15_tx", tx_byte, 8'h00);
        send(8'h00);
        chk("rd15_fixed_tx", tx_byte, 8'h00);
`endif
        end_frame();
        start_frame(); send(8'h8E);
`ifdef SPI_REGS_AUTOINC_EN
        chk("rd14_tx", tx_byte, 8'h11);
        send(8'h00);
        chk("rd14_next_tx", tx_byte, 8'h22);
`else
        chk("rd14_tx", tx_byte, 8'h33);
        send(8'h00);
        chk("rd14_fixed_tx", tx_byte, 8'h33);
`endif
        end_frame();

        // frame_start with rx_valid: byte dropped, no error
        frame_start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h81;
        tick();
        frame_start = 1'b0; rx_valid = 1'b0;
        chk("fsrx_state", {5'd0, state_dbg}, {5'd0, S_CMD});
        chk("fsrx_tx", tx_byte, 8'h00);
        chk("fsrx_err", {7'd0, err}, 8'h00);
        send(8'h81);
        chk("fsrx_rd1", tx_byte, 8'h01);
        end_frame();

        // rx_valid with frame_end: byte written, then idle
        start_frame(); send(8'h01);
        rx_valid = 1'b1; rx_byte = 8'h5A; frame_end = 1'b1;
        tick();
        rx_valid = 1'b0; frame_end = 1'b0;
        chk("rxfe_ctrl", ctrl_out, 8'h5A);
        chk("rxfe_led", {7'd0, LED}, 8'h00);
        chk("rxfe_state", {5'd0, state_dbg}, {5'd0, S_IDLE});
        chk("rxfe_err", {7'd0, err}, 8'h00);

        // frame_end with frame_start: back to CMD, tx cleared
        start_frame(); send(8'h81);
        chk("fefs_pre_tx", tx_byte, 8'h5A);
        frame_end = 1'b1; frame_start = 1'b1;
        tick();
        frame_end = 1'b0; frame_start = 1'b0;
        chk("fefs_state", {5'd0, state_dbg}, {5'd0, S_CMD});
        chk("fefs_tx", tx_byte, 8'h00);
        end_frame();

        // Reserved bits set: discard and sticky error
        start_frame(); send(8'h50);
        chk("rsv_err", {7'd0, err}, 8'h01);
        chk("rsv_state", {5'd0, state_dbg}, {5'd0, S_DISCARD});
        send(8'hFF);
        chk("rsv_ctrl", ctrl_out, 8'h5A);
        chk("rsv_state2", {5'd0, state_dbg}, {5'd0, S_DISCARD});
        end_frame();
        start_frame(); send(8'h81);
        chk("rsv_later_tx", tx_byte, 8'h5A);
        chk("rsv_sticky_err", {7'd0, err}, 8'h01);
        end_frame();

        // Reset in the middle of a write frame
        start_frame(); send(8'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_state", {5'd0, state_dbg}, {5'd0, S_IDLE});
        chk("mrst_ctrl", ctrl_out, 8'h00);
        chk("mrst_err", {7'd0, err}, 8'h00);
        send(8'h77);
        chk("idle_rx_err", {7'd0, err}, 8'h01);
        chk("idle_rx_ctrl", ctrl_out, 8'h00);
        start_frame(); send(8'h81);
        chk("mrst_rd1", tx_byte, 8'h00);
        end_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
